// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: 11-bit frames checked for start/parity/stop, good bytes queued in a show-ahead FIFO.
// Byte visible 2 clk after synced stop-bit fall; rd_en pops next edge; byte dropped with overflow pulse when full and not popped.
module ps2_rx_fifo #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rd_en,
    output logic [7:0] code,
    output logic       empty,
    output logic       full,
    output logic       frame_err,
    output logic       overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic          clk_s1, clk_s2, clk_prev, dat_s1, dat_s2;
    logic          fall;
    state_t        state, state_nxt;
    logic [7:0]    shreg, shreg_nxt;
    logic [2:0]    bit_cnt, bit_cnt_nxt;
    logic          parity_ok, parity_ok_nxt;
    logic [TW-1:0] tmo_cnt;
    logic          push, ferr_nxt;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic          do_push, do_pop;

    // Synchronizers reset high so releasing reset never looks like a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            dat_s1   <= ps2_data;
            dat_s2   <= dat_s1;
        end
    end

    assign fall = clk_prev & ~clk_s2;

    always_comb begin
        state_nxt     = state;
        shreg_nxt     = shreg;
        bit_cnt_nxt   = bit_cnt;
        parity_ok_nxt = parity_ok;
        push          = 1'b0;
        ferr_nxt      = 1'b0;
        if (fall) begin
            case (state)
                IDLE: begin
                    if (!dat_s2) begin
                        state_nxt   = DATA;
                        bit_cnt_nxt = 3'd0;
                    end
                end
                DATA: begin
                    shreg_nxt   = {dat_s2, shreg[7:1]};
                    bit_cnt_nxt = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_nxt = PARITY;
                end
                PARITY: begin
                    parity_ok_nxt = ^{shreg, dat_s2};
                    state_nxt     = STOP;
                end
                STOP: begin
                    if (dat_s2 && parity_ok) push = 1'b1;
                    else                     ferr_nxt = 1'b1;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end else if (state != IDLE && tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            state_nxt = IDLE;
            ferr_nxt  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shreg     <= 8'h00;
            bit_cnt   <= 3'd0;
            parity_ok <= 1'b0;
            tmo_cnt   <= '0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_nxt;
            shreg     <= shreg_nxt;
            bit_cnt   <= bit_cnt_nxt;
            parity_ok <= parity_ok_nxt;
            tmo_cnt   <= (fall || state_nxt == IDLE) ? '0 : tmo_cnt + TW'(1);
            frame_err <= ferr_nxt;
            overflow  <= push & full & ~rd_en;
        end
    end

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign do_pop  = rd_en & ~empty;
    assign do_push = push & (~full | do_pop);

    assign empty = (count == '0);
    assign full  = (count == (AW + 1)'(FIFO_DEPTH));
    assign code  = empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule
